// File: rtl/uart_lcd_pkg.sv
// Shared constants for the UART-to-LCD text path: control codes, printable
// range and the text-buffer FSM state encoding.
package uart_lcd_pkg;

    localparam logic [7:0] CHR_BS       = 8'h08;
    localparam logic [7:0] CHR_LF       = 8'h0A;
    localparam logic [7:0] CHR_FF       = 8'h0C;
    localparam logic [7:0] CHR_CR       = 8'h0D;
    localparam logic [7:0] CHR_SPACE    = 8'h20;
    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } tb_state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CHR_PRINT_LO) && (b <= CHR_PRINT_HI);
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect: turns a slow-domain strobe
// of any length into a single i_clk-wide pulse.
module pulse_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);

    logic s1_q, s2_q, edge_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= i_async;
            s2_q   <= s1_q;
            edge_q <= s2_q;
        end
    end

    assign o_pulse = s2_q & ~edge_q;

endmodule

// File: rtl/uart_text_buffer.sv
// Character RAM and cursor driven by received UART bytes; the LCD refresh
// engine reads the RAM through a registered port and watches o_dirty.
module uart_text_buffer
    import uart_lcd_pkg::*;
#(
    parameter int COLS   = 16,
    parameter int ROWS   = 2,
    parameter int ADDR_W = $clog2(COLS*ROWS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic              o_busy,
    output logic              o_dirty,
    input  logic              i_dirty_clr,
    output logic              o_overrun
);

    localparam int                N        = COLS * ROWS;
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(N - 1);

    logic              accept;
    logic [7:0]        byte_q;
    logic              byte_vld_q;
    tb_state_e         state_q;
    logic [ADDR_W-1:0] clr_cnt_q, row_q, col_q, cur_addr_q;
    logic [ADDR_W-1:0] row_d, col_d, cur_addr_d;
    logic              dirty_q, overrun_q;
    logic [7:0]        rd_data_q;
    logic              we, go_clear, drop, clr_done;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic [7:0]        mem [N];

    pulse_sync_edge u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_rx_valid),
        .o_pulse (accept)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) byte_vld_q <= 1'b0;
        else       byte_vld_q <= accept;
    end

    always_ff @(posedge i_clk) begin
        if (accept) byte_q <= i_rx_data;
    end

    // Decode one byte per cycle into a RAM write and the next cursor.
    always_comb begin
        we       = 1'b0;
        waddr    = cur_addr_q;
        wdata    = CHR_SPACE;
        row_d    = row_q;
        col_d    = col_q;
        go_clear = 1'b0;
        drop     = 1'b0;
        clr_done = 1'b0;
        if (state_q == ST_CLEAR) begin
            we    = 1'b1;
            waddr = clr_cnt_q;
            drop  = byte_vld_q;
            if (clr_cnt_q == CLR_LAST) begin
                clr_done = 1'b1;
                row_d    = '0;
                col_d    = '0;
            end
        end else if (byte_vld_q) begin
            case (byte_q)
                CHR_CR: col_d = '0;
                CHR_LF: row_d = (row_q == ROW_LAST) ? '0 : row_q + ADDR_W'(1);
                CHR_BS: begin
                    if (col_q != '0) begin
                        col_d = col_q - ADDR_W'(1);
                        we    = 1'b1;
                        waddr = cur_addr_q - ADDR_W'(1);
                    end
                end
                CHR_FF: go_clear = 1'b1;
                default: begin
                    if (is_printable(byte_q)) begin
                        we    = 1'b1;
                        wdata = byte_q;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = (row_q == ROW_LAST) ? '0 : row_q + ADDR_W'(1);
                        end else begin
                            col_d = col_q + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
        cur_addr_d = row_d * COLS_A + col_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            cur_addr_q <= '0;
            dirty_q    <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            cur_addr_q <= cur_addr_d;
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (clr_done) begin
                        state_q   <= ST_IDLE;
                        clr_cnt_q <= '0;
                    end
                end
                default: begin
                    if (go_clear) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                    end
                end
            endcase
            if (we || clr_done) dirty_q <= 1'b1;
            else if (i_dirty_clr) dirty_q <= 1'b0;
            if (drop) overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read-first: the same-cycle write lands after this read samples the array.
    always_ff @(posedge i_clk) begin
        if (i_rst) rd_data_q <= 8'h00;
        else       rd_data_q <= mem[i_rd_addr];
    end

    assign o_rd_data  = rd_data_q;
    assign o_cur_addr = cur_addr_q;
    assign o_busy     = (state_q == ST_CLEAR);
    assign o_dirty    = dirty_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_text_buffer.sv
// Bench for uart_text_buffer: random text and control codes checked against
// a linear-cursor reference model of the 16x2 character screen.
module tb_uart_text_buffer;

    localparam int COLS = 16;
    localparam int ROWS = 2;
    localparam int N    = COLS * ROWS;
    localparam int AW   = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic [AW-1:0] cur_addr;
    logic          busy, dirty, dirty_clr = 1'b0, overrun;

    int total = 0;
    int bad   = 0;

    // Reference model
    byte unsigned m_mem [N];
    int           m_cur;
    bit           m_dirty;
    bit           m_overrun;

    uart_text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_cur_addr  (cur_addr),
        .o_busy      (busy),
        .o_dirty     (dirty),
        .i_dirty_clr (dirty_clr),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_mem[i] = 8'h20;
        m_cur   = 0;
        m_dirty = 1'b1;
    endfunction

    function automatic void model_byte(input byte unsigned b);
        int row, col;
        row = m_cur / COLS;
        col = m_cur % COLS;
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_mem[m_cur] = b;
            m_cur        = (m_cur + 1) % N;
            m_dirty      = 1'b1;
        end else if (b == 8'h0D) begin
            m_cur = row * COLS;
        end else if (b == 8'h0A) begin
            m_cur = ((row + 1) % ROWS) * COLS + col;
        end else if (b == 8'h08) begin
            if (col > 0) begin
                m_cur        = m_cur - 1;
                m_mem[m_cur] = 8'h20;
                m_dirty      = 1'b1;
            end
        end
    endfunction

    task automatic send(input byte unsigned b, input int hold);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) tick();
        rx_valid = 1'b0;
        repeat (6) tick();
        model_byte(b);
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a);
            tick();
            total++;
            if (rd_data !== m_mem[a]) begin
                bad++;
                $display("FAIL %s ram[%0d]: got %02h want %02h", tag, a, rd_data, m_mem[a]);
            end
        end
    endtask

    task automatic check_cur(input string tag);
        total++;
        if (cur_addr !== AW'(m_cur)) begin
            bad++;
            $display("FAIL %s cur_addr: got %0d want %0d", tag, cur_addr, m_cur);
        end
    endtask

    task automatic do_reset_and_wait(output int busy_cycles);
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (rd_data !== 8'h00 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_vals: rd_data=%02h busy=%b want 00/1", rd_data, busy);
        end
        rst = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            tick();
        end
        model_clear();
        m_overrun = 1'b0;
    endtask

    task automatic test_reset();
        int bc;
        do_reset_and_wait(bc);
        total++;
        if (bc != N) begin
            bad++;
            $display("FAIL reset_busy_len: got %0d want %0d", bc, N);
        end
        check_cur("reset");
        total++;
        if (dirty !== 1'b1 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: dirty=%b overrun=%b want 1/0", dirty, overrun);
        end
        check_ram("reset");
    endtask

    task automatic test_held_strobe();
        int lat;
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        lat = 0;
        while (cur_addr !== AW'(1) && lat < 10) begin
            tick();
            lat++;
        end
        total++;
        if (lat > 4) begin
            bad++;
            $display("FAIL accept_latency: got %0d cycles want <=4", lat);
        end
        repeat (10) tick();
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        repeat (1390) tick();
        rx_valid = 1'b0;
        repeat (6) tick();
        model_byte(8'h41);
        m_dirty = 1'b0;
        total++;
        if (dirty !== m_dirty) begin
            bad++;
            $display("FAIL held_single_write dirty: got %b want %b", dirty, m_dirty);
        end
        check_cur("held_A");
        send(8'h42, 1);
        check_cur("short_B");
        check_ram("AB");
    endtask

    task automatic test_wrap();
        int bc;
        byte unsigned b;
        do_reset_and_wait(bc);
        for (int i = 0; i < N; i++) begin
            b = byte'($urandom_range(8'h20, 8'h7E));
            send(b, $urandom_range(1, 20));
            if (i == COLS - 1) check_cur("wrap_row");
        end
        check_cur("wrap_full");
        check_ram("wrap");
    endtask

    task automatic test_controls();
        for (int i = 0; i < 5; i++) send(byte'($urandom_range(8'h21, 8'h7E)), 2);
        check_cur("ctl_at5");
        send(8'h08, 3);
        check_cur("ctl_bs");
        send(8'h0D, 3);
        check_cur("ctl_cr");
        send(8'h08, 3);
        check_cur("ctl_bs_col0");
        send(8'h0A, 3);
        check_cur("ctl_lf1");
        send(8'h0A, 3);
        check_cur("ctl_lf2");
        check_ram("ctl");
    endtask

    task automatic test_random_mix();
        byte unsigned pool [6] = '{8'h08, 8'h0A, 8'h0D, 8'h07, 8'h1B, 8'h7F};
        byte unsigned b;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) b = pool[$urandom_range(0, 5)];
            else                           b = byte'($urandom_range(8'h20, 8'h7E));
            send(b, $urandom_range(1, 30));
            check_cur("rand");
        end
        check_ram("rand");
    endtask

    task automatic test_clear_overrun();
        int bc;
        int first;
        bc    = 0;
        first = -1;
        for (int i = 0; i < 60; i++) begin
            if (i == 0)  begin rx_data = 8'h0C; rx_valid = 1'b1; end
            if (i == 1)  rx_valid = 1'b0;
            if (i == 10) begin rx_data = 8'h5A; rx_valid = 1'b1; end
            if (i == 11) rx_valid = 1'b0;
            tick();
            if (busy === 1'b1) begin
                bc++;
                if (first < 0) first = i + 1;
            end
        end
        model_clear();
        m_overrun = 1'b1;
        total++;
        if (bc != N || first > 4 || first < 0) begin
            bad++;
            $display("FAIL ff_busy: got %0d cycles from cycle %0d want %0d from <=4", bc, first, N);
        end
        total++;
        if (overrun !== m_overrun) begin
            bad++;
            $display("FAIL overrun: got %b want %b", overrun, m_overrun);
        end
        check_cur("ff");
        check_ram("ff");
    endtask

    task automatic test_dirty();
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        m_dirty = 1'b0;
        total++;
        if (dirty !== m_dirty) begin
            bad++;
            $display("FAIL dirty_clr: got %b want %b", dirty, m_dirty);
        end
        // The write lands on the fourth edge after the strobe rises.
        rx_data  = 8'h51;
        rx_valid = 1'b1;
        repeat (3) tick();
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        rx_valid  = 1'b0;
        repeat (6) tick();
        model_byte(8'h51);
        total++;
        if (dirty !== m_dirty) begin
            bad++;
            $display("FAIL dirty_set_wins: got %b want %b", dirty, m_dirty);
        end
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        m_dirty = 1'b0;
        send(8'h07, 2);
        total++;
        if (dirty !== m_dirty) begin
            bad++;
            $display("FAIL ignored_code dirty: got %b want %b", dirty, m_dirty);
        end
        check_cur("ignored");
        check_ram("dirty");
    endtask

    initial begin
        test_reset();
        test_held_strobe();
        test_wrap();
        test_controls();
        test_random_mix();
        test_clear_overrun();
        test_dirty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
